// File: rtl/ttt_turn_scheduler.sv
// Turn scheduler and move arbiter for the tic-tac-toe board: grants turns, validates
// squares, issues write/clear strobes, enforces the turn timeout and tracks game over.
module ttt_turn_scheduler #(
    parameter int TURN_TIMEOUT = 1000,
    parameter int FIRST_MOVER  = 0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       play,
    input  logic [3:0] player_position,
    input  logic       pc,
    input  logic [3:0] computer_position,
    input  logic [8:0] occupied,
    input  logic       win,
    input  logic [1:0] who,
    input  logic       no_space,
    output logic       move_we,
    output logic [1:0] move_who,
    output logic [3:0] move_pos,
    output logic       board_clear,
    output logic [1:0] turn,
    output logic       illegal,
    output logic       timeout,
    output logic       game_over,
    output logic [1:0] winner,
    output logic [3:0] move_count
);

    localparam int TW = (TURN_TIMEOUT > 0) ? $clog2(TURN_TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] EXPIRE_AT = (TURN_TIMEOUT > 0) ? TW'(TURN_TIMEOUT - 1) : '0;
    localparam logic [TW-1:0] TIMER_MAX = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_P_TURN,
        S_C_TURN,
        S_EVAL,
        S_DONE
    } state_t;

    state_t        state, state_nx;
    logic [TW-1:0] timer, timer_nx;
    logic [3:0]    count_nx;
    logic [1:0]    winner_nx;
    logic          last_pc, last_pc_nx;
    logic          expire;
    logic          p_valid, c_valid;

    // Positions above 8 are rejected before indexing, so the widened vector is never read past bit 8.
    function automatic logic square_free(input logic [3:0] pos, input logic [8:0] occ);
        logic [15:0] ext;
        ext = {7'b0, occ};
        return (pos <= 4'd8) && !ext[pos];
    endfunction

    assign p_valid = play && square_free(player_position, occupied);
    assign c_valid = pc && square_free(computer_position, occupied);
    assign expire  = (TURN_TIMEOUT != 0) && (timer == EXPIRE_AT);

    always_comb begin
        state_nx    = state;
        count_nx    = move_count;
        winner_nx   = winner;
        last_pc_nx  = last_pc;
        move_we     = 1'b0;
        move_who    = 2'b00;
        move_pos    = 4'd0;
        board_clear = 1'b0;
        turn        = 2'b00;
        illegal     = 1'b0;
        timeout     = 1'b0;
        game_over   = 1'b0;

        case (state)
            S_IDLE, S_DONE: begin
                game_over = (state == S_DONE);
                if (start) begin
                    board_clear = 1'b1;
                    count_nx    = 4'd0;
                    winner_nx   = 2'b00;
                    state_nx    = (FIRST_MOVER != 0) ? S_C_TURN : S_P_TURN;
                end
            end
            S_P_TURN: begin
                turn = 2'b01;
                // A valid move beats expiry; expiry beats a bad request so the turn can still end.
                if (p_valid) begin
                    move_we    = 1'b1;
                    move_who   = 2'b01;
                    move_pos   = player_position;
                    count_nx   = move_count + 4'd1;
                    last_pc_nx = 1'b0;
                    state_nx   = S_EVAL;
                end else if (expire) begin
                    timeout  = 1'b1;
                    state_nx = S_C_TURN;
                end else if (play) begin
                    illegal = 1'b1;
                end
            end
            S_C_TURN: begin
                turn = 2'b10;
                if (c_valid) begin
                    move_we    = 1'b1;
                    move_who   = 2'b10;
                    move_pos   = computer_position;
                    count_nx   = move_count + 4'd1;
                    last_pc_nx = 1'b1;
                    state_nx   = S_EVAL;
                end else if (expire) begin
                    timeout  = 1'b1;
                    state_nx = S_P_TURN;
                end else if (pc) begin
                    illegal = 1'b1;
                end
            end
            S_EVAL: begin
                if (win) begin
                    winner_nx = who;
                    state_nx  = S_DONE;
                end else if (no_space) begin
                    winner_nx = 2'b00;
                    state_nx  = S_DONE;
                end else begin
                    state_nx = last_pc ? S_P_TURN : S_C_TURN;
                end
            end
            default: state_nx = S_IDLE;
        endcase

        // Strobes are suppressed while reset is held so an abandoned turn never writes the board.
        if (!reset) begin
            move_we     = 1'b0;
            move_who    = 2'b00;
            move_pos    = 4'd0;
            board_clear = 1'b0;
            illegal     = 1'b0;
            timeout     = 1'b0;
        end

        if (state_nx != state)
            timer_nx = '0;
        else if ((state == S_P_TURN || state == S_C_TURN) && timer != TIMER_MAX)
            timer_nx = timer + 1'b1;
        else
            timer_nx = timer;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= S_IDLE;
            timer      <= '0;
            move_count <= 4'd0;
            winner     <= 2'b00;
            last_pc    <= 1'b0;
        end else begin
            state      <= state_nx;
            timer      <= timer_nx;
            move_count <= count_nx;
            winner     <= winner_nx;
            last_pc    <= last_pc_nx;
        end
    end

endmodule

// File: doc/ttt_turn_scheduler.md
# ttt_turn_scheduler

Turn scheduler and move arbiter for the tic-tac-toe board datapath. Sits between the player button inputs, the computer move source and the nine position registers. Grants exactly one side per turn, validates each requested square against the board, and issues a single-cycle write strobe. Enforces a per-turn timeout, samples win/draw after every move, and owns board clear and game-over status.

## Interface
Parameters:
- TURN_TIMEOUT, 1000: cycles a side may hold its turn before forfeiting; 0 disables timeout.
- FIRST_MOVER, 0: side that moves first after start; 0 = player, 1 = computer.

Ports:
- clock  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  begin a new game; sampled only in IDLE or DONE.
- play  in  1  player move request, level-sampled.
- player_position  in  4  player square, 0..8 valid.
- pc  in  1  computer move request, level-sampled.
- computer_position  in  4  computer square, 0..8 valid.
- occupied  in  9  bit i = square i non-empty (from board).
- win  in  1  combinational winner flag from board.
- who  in  2  winner code from board (01 player, 10 computer).
- no_space  in  1  board full.
- move_we  out  1  one-cycle board write strobe.
- move_who  out  2  01 player, 10 computer; 00 when move_we=0.
- move_pos  out  4  square written; 0 when move_we=0.
- board_clear  out  1  one-cycle board clear strobe.
- turn  out  2  01 player turn, 10 computer turn, 00 otherwise.
- illegal  out  1  one-cycle pulse on rejected request.
- timeout  out  1  one-cycle pulse on turn forfeit.
- game_over  out  1  high in DONE.
- winner  out  2  latched winner; 00 = none/draw.
- move_count  out  4  accepted moves this game, 0..9.

## Operation
- States: IDLE, P_TURN, C_TURN, EVAL, DONE.
- IDLE: turn=00. On start: board_clear=1 for one cycle, move_count:=0, winner:=00; go to P_TURN if FIRST_MOVER=0, else C_TURN.
- P_TURN (turn=01): pc/computer_position ignored. If play=1:
  - Valid request (player_position<=8 and occupied[player_position]=0): move_we=1, move_who=01, move_pos=player_position, move_count+1; go to EVAL.
  - Invalid request: illegal=1; stay in P_TURN; no write.
  - Else if the turn timer expires: timeout=1; go to C_TURN with no write.
- C_TURN (turn=10): mirror of P_TURN using pc/computer_position, move_who=10; a timeout goes to P_TURN.
- EVAL (turn=00, one cycle): samples win/no_space against the updated board.
  - win=1: winner:=who; go to DONE.
  - Else no_space=1: winner:=00; go to DONE.
  - Else: go to the opposite side of the move just made.
- DONE: game_over=1; winner and move_count held; play/pc ignored. start behaves as in IDLE (clear, new game).
- Turn timer: cleared on entry to P_TURN/C_TURN and increments each cycle in that state. It expires when count = TURN_TIMEOUT-1 and no valid move is present that cycle. A valid move takes priority over expiry in the same cycle. Illegal requests do not clear the timer. Width is clog2(TURN_TIMEOUT+1), saturating. Never expires when TURN_TIMEOUT=0.
- A held play/pc level produces at most one move: after EVAL, the next turn belongs to the other side. A still-asserted request from the side that just moved is ignored.
- Repeated invalid requests produce illegal on every cycle they are presented.

## Timing
- Reset (reset=0 at a clock edge): state IDLE; all outputs 0; move_count=0; winner=00; timer=0. Reset mid-game abandons the game; board_clear is not issued by reset, and the board has its own reset.
- Move latency: request sampled at cycle t → move_we at cycle t (combinational from state and inputs). Board updates at end of t. EVAL at t+1. Next turn or DONE at t+2.
- Minimum full turn is 2 cycles. A 9-move game without timeouts completes in 18 cycles plus request waits.
- start → board_clear in the same cycle; the first turn state begins the next cycle.
- illegal, timeout, move_we and board_clear are mutually exclusive within a cycle.
- game_over rises the cycle after EVAL and stays high until start or reset.

## Test plan
- Reset then start with FIRST_MOVER=0: board_clear pulses once and turn=01. play with position 4 → move_we=1, move_who=01, move_pos=4, then turn=10 two cycles later, move_count=1.
- Occupied square: occupied[4]=1, computer requests 4 → illegal=1, no move_we, turn stays 10. Computer then requests 0 → accepted.
- Player wins on squares 0, 1, 2 (win=1, who=01 after third write) → DONE, game_over=1, winner=01, move_count=5. Further play/pc produce no move_we.
- Draw: 9 valid alternating moves, last with no_space=1 and win=0 → game_over=1, winner=00, move_count=9.
- TURN_TIMEOUT=4, player idle → timeout pulses on the 4th P_TURN cycle and turn=10 next cycle. A valid play presented on that 4th cycle is accepted, with no timeout.
- Reset asserted in C_TURN with pc=1 → no move_we at that edge; all outputs 0 next cycle. start required to resume.
